// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Recovers the digit values shown on a multiplexed, common-anode
//   seven-segment display by watching its anode and cathode lines. Each
//   lit position is captured once its {AN,seg} pattern has been sampled
//   unchanged STABLE times in a row.
//
//   Parameters
//     NDIG    number of scanned digit positions (1..8)
//     STABLE  identical samples required before a capture (2..255)
//
//   Ports
//     clk     rising-edge clock
//     rst     asynchronous reset, active low
//     AN      anode enables, active low, one-hot-low when a digit is lit
//     seg     cathodes a..g (seg[1]=a .. seg[7]=g), active low
//     digits  decoded value per position, digit i at [4i+3:4i]
//     valid   bit i set while digit i holds a decoded value
//     upd     one-cycle pulse when a capture changes digits or valid
//     frame   one-cycle pulse when the scan returns to a captured position
//     err     sticky: bad segment pattern or ghosted anodes
//
//   Build option
//     SEG_SCAN_HEX_EN  when defined, also decode A b C d E F as 10..15
module seg_scan_decoder #(
    parameter int NDIG   = 8,
    parameter int STABLE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NDIG-1:0]   AN,
    input  logic [1:7]        seg,
    output logic [4*NDIG-1:0] digits,
    output logic [NDIG-1:0]   valid,
    output logic              upd,
    output logic              frame,
    output logic              err
);
    localparam int PW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;

    state_t               state;
    logic [NDIG-1:0]      an_s, an_p;     // sample stage and the sample before it
    logic [6:0]           seg_s, seg_p;   // bit 6 = segment a
    logic [7:0]           cnt;            // identical-sample run length
    logic [7:0]           gcnt;           // consecutive multi-anode samples
    logic [NDIG-1:0]      seen;
    logic [NDIG-1:0][3:0] dig_q;

    logic          one_hot, multi, changed, stable_hit, ghost_hit;
    logic [PW-1:0] pos;
    logic [6:0]    pat;
    logic [3:0]    dec_val;
    logic          dec_ok, dec_blank;

    assign digits     = dig_q;
    assign one_hot    = $onehot(~an_s);
    assign multi      = !$onehot0(~an_s);
    assign changed    = (an_s != an_p) || (seg_s != seg_p);
    // the current sample would be the STABLE-th identical one
    assign stable_hit = ({1'b0, cnt} + 9'd1) >= 9'(STABLE);
    assign ghost_hit  = multi && (({1'b0, gcnt} + 9'd1) >= 9'(STABLE));
    assign pat        = ~seg_s;  // active-high a..g

    always_comb begin
        pos = '0;
        for (int i = 0; i < NDIG; i++)
            if (!an_s[i]) pos = PW'(i);
    end

    always_comb begin
        dec_val   = '0;
        dec_ok    = 1'b1;
        dec_blank = 1'b0;
        case (pat)
            7'b1111110: dec_val = 4'd0;
            7'b0110000: dec_val = 4'd1;
            7'b1101101: dec_val = 4'd2;
            7'b1111001: dec_val = 4'd3;
            7'b0110011: dec_val = 4'd4;
            7'b1011011: dec_val = 4'd5;
            7'b1011111: dec_val = 4'd6;
            7'b1110000: dec_val = 4'd7;
            7'b1111111: dec_val = 4'd8;
            7'b1111011: dec_val = 4'd9;
`ifdef SEG_SCAN_HEX_EN
            7'b1110111: dec_val = 4'd10;
            7'b0011111: dec_val = 4'd11;
            7'b1001110: dec_val = 4'd12;
            7'b0111101: dec_val = 4'd13;
            7'b1001111: dec_val = 4'd14;
            7'b1000111: dec_val = 4'd15;
`endif
            7'b0000000: begin
                dec_ok    = 1'b0;
                dec_blank = 1'b1;
            end
            default:    dec_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            an_s  <= '1;
            an_p  <= '1;
            seg_s <= '1;
            seg_p <= '1;
            cnt   <= '0;
            gcnt  <= '0;
            seen  <= '0;
            dig_q <= '0;
            valid <= '0;
            upd   <= 1'b0;
            frame <= 1'b0;
            err   <= 1'b0;
        end else begin
            an_s  <= AN;
            seg_s <= seg;
            an_p  <= an_s;
            seg_p <= seg_s;
            upd   <= 1'b0;
            frame <= 1'b0;

            // ghosting is tracked independently of the capture FSM
            if (multi) begin
                if (gcnt != 8'hFF) gcnt <= gcnt + 8'd1;
                if (ghost_hit) err <= 1'b1;
            end else begin
                gcnt <= '0;
            end

            case (state)
                IDLE: begin
                    if (one_hot) begin
                        state <= SETTLE;
                        cnt   <= 8'd1;
                    end else begin
                        cnt   <= '0;
                    end
                end
                SETTLE: begin
                    if (changed) begin
                        if (one_hot) begin
                            cnt   <= 8'd1;
                        end else begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end else if (stable_hit) begin
                        state <= CAPTURE;
                        cnt   <= 8'(STABLE);
                        if (dec_ok) begin
                            dig_q[pos] <= dec_val;
                            valid[pos] <= 1'b1;
                            upd        <= (dig_q[pos] != dec_val) || !valid[pos];
                        end else begin
                            valid[pos] <= 1'b0;
                            upd        <= valid[pos];
                            if (!dec_blank) err <= 1'b1;
                        end
                        if (seen[pos]) begin
                            frame     <= 1'b1;
                            seen      <= '0;
                            seen[pos] <= 1'b1;
                        end else begin
                            seen[pos] <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                // a change during the capture cycle is honoured immediately
                CAPTURE, HOLD: begin
                    if (changed) begin
                        if (one_hot) begin
                            state <= SETTLE;
                            cnt   <= 8'd1;
                        end else begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end else begin
                        state <= HOLD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder
//   Table of single-digit decode vectors, hand-written multi-cycle
//   sequences, and random scan traffic compared every cycle against a
//   reference model built on run lengths of the applied inputs.
module tb_seg_scan_decoder;
    localparam int NDIG   = 8;
    localparam int STABLE = 4;
`ifdef SEG_SCAN_HEX_EN
    localparam bit HEX = 1'b1;
`else
    localparam bit HEX = 1'b0;
`endif
    // active-high a..g codes for values 0..15, bit 6 = a
    localparam logic [6:0] CODES [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B,
                                          7'h5F, 7'h70, 7'h7F, 7'h7B, 7'h77, 7'h1F,
                                          7'h4E, 7'h3D, 7'h4F, 7'h47};

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NDIG-1:0]   AN  = '1;
    logic [1:7]        seg = '1;
    logic [4*NDIG-1:0] digits;
    logic [NDIG-1:0]   valid;
    logic              upd, frame, err;

    seg_scan_decoder #(.NDIG(NDIG), .STABLE(STABLE)) dut (
        .clk(clk), .rst(rst), .AN(AN), .seg(seg),
        .digits(digits), .valid(valid), .upd(upd), .frame(frame), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    int upd_cnt = 0, frame_cnt = 0, last_upd = -1;

    // reference model state
    logic [NDIG-1:0] m_an_s;
    logic [6:0]      m_seg_s;
    int              m_run, m_ghost;
    logic [3:0]      m_dig [NDIG];
    logic [NDIG-1:0] m_vld, m_seen;
    logic            m_upd, m_frame, m_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int count_low(input logic [NDIG-1:0] a);
        int n = 0;
        for (int i = 0; i < NDIG; i++) if (!a[i]) n++;
        return n;
    endfunction

    function automatic int low_index(input logic [NDIG-1:0] a);
        for (int i = 0; i < NDIG; i++) if (!a[i]) return i;
        return 0;
    endfunction

    // value 0..15, -1 for blank, -2 for anything unrecognised
    function automatic int decode(input logic [6:0] p);
        int lim = HEX ? 16 : 10;
        if (p == 7'h00) return -1;
        for (int v = 0; v < lim; v++) if (CODES[v] == p) return v;
        return -2;
    endfunction

    task automatic model_reset();
        m_an_s  = '1;
        m_seg_s = '1;
        m_run   = 0;
        m_ghost = 0;
        for (int i = 0; i < NDIG; i++) m_dig[i] = '0;
        m_vld   = '0;
        m_seen  = '0;
        m_upd   = 1'b0;
        m_frame = 1'b0;
        m_err   = 1'b0;
    endtask

    // One rising edge: the pattern sampled last edge is acted on if it
    // has now been seen exactly STABLE times in a row, then the newly
    // applied inputs become the sample.
    task automatic model_edge();
        int p, v;
        logic [3:0] od;
        logic       ov;
        m_upd   = 1'b0;
        m_frame = 1'b0;
        if (m_run == STABLE && count_low(m_an_s) == 1) begin
            p  = low_index(m_an_s);
            v  = decode(~m_seg_s);
            od = m_dig[p];
            ov = m_vld[p];
            if (v >= 0) begin
                m_dig[p] = 4'(v);
                m_vld[p] = 1'b1;
            end else begin
                m_vld[p] = 1'b0;
                if (v == -2) m_err = 1'b1;
            end
            m_upd = (m_dig[p] != od) || (m_vld[p] != ov);
            if (m_seen[p]) begin
                m_frame = 1'b1;
                m_seen  = '0;
            end
            m_seen[p] = 1'b1;
        end
        if (m_ghost >= STABLE) m_err = 1'b1;
        if (AN == m_an_s && 7'(seg) == m_seg_s) begin
            if (m_run <= STABLE) m_run++;
        end else begin
            m_run = 1;
        end
        if (count_low(AN) > 1) begin
            if (m_ghost < STABLE) m_ghost++;
        end else begin
            m_ghost = 0;
        end
        m_an_s  = AN;
        m_seg_s = seg;
    endtask

    task automatic compare();
        logic [4*NDIG-1:0] md;
        for (int i = 0; i < NDIG; i++) md[4*i +: 4] = m_dig[i];
        chk("digits", digits, md);
        chk("valid", valid, m_vld);
        chk("upd", upd, m_upd);
        chk("frame", frame, m_frame);
        chk("err", err, m_err);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (rst) model_edge();
        #1;
        compare();
        if (upd) begin
            upd_cnt++;
            last_upd = cyc;
        end
        if (frame) frame_cnt++;
    endtask

    task automatic drive(input logic [NDIG-1:0] a, input logic [6:0] s, input int n);
        AN  = a;
        seg = s;
        repeat (n) tick();
    endtask

    // asynchronous assert, one edge held in reset, release just after an edge
    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        compare();
        tick();
        rst       = 1'b1;
        upd_cnt   = 0;
        frame_cnt = 0;
        last_upd  = -1;
    endtask

    typedef struct {
        logic [NDIG-1:0] an;
        logic [6:0]      sg;   // active-low a..g
        logic [3:0]      val;
        logic            vld;
        logic            er;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int c0, p, hold;
        logic [NDIG-1:0] a;
        logic [6:0]      s;

        tbl.push_back('{8'hFE, 7'b0000001, 4'd0, 1'b1, 1'b0});
        tbl.push_back('{8'hFD, 7'b1001111, 4'd1, 1'b1, 1'b0});
        tbl.push_back('{8'hFB, 7'b0010010, 4'd2, 1'b1, 1'b0});
        tbl.push_back('{8'hF7, 7'b0000110, 4'd3, 1'b1, 1'b0});
        tbl.push_back('{8'hEF, 7'b1001100, 4'd4, 1'b1, 1'b0});
        tbl.push_back('{8'hDF, 7'b0100100, 4'd5, 1'b1, 1'b0});
        tbl.push_back('{8'hBF, 7'b0100000, 4'd6, 1'b1, 1'b0});
        tbl.push_back('{8'h7F, 7'b0001111, 4'd7, 1'b1, 1'b0});
        tbl.push_back('{8'hFE, 7'b0000000, 4'd8, 1'b1, 1'b0});
        tbl.push_back('{8'hFD, 7'b0000100, 4'd9, 1'b1, 1'b0});
        tbl.push_back('{8'hFB, 7'b1111111, 4'd0, 1'b0, 1'b0});  // blank
        tbl.push_back('{8'hF7, 7'b0000011, 4'd0, 1'b0, 1'b1});  // not a digit
`ifdef SEG_SCAN_HEX_EN
        tbl.push_back('{8'hFD, 7'b0110000, 4'd14, 1'b1, 1'b0}); // 'E'
`else
        tbl.push_back('{8'hFD, 7'b0110000, 4'd0, 1'b0, 1'b1});  // 'E'
`endif

        #2;
        do_reset();

        foreach (tbl[k]) begin
            do_reset();
            drive(tbl[k].an, tbl[k].sg, STABLE + 3);
            p = low_index(tbl[k].an);
            chk("tbl_digit", digits[4*p +: 4], tbl[k].val);
            chk("tbl_valid", valid[p], tbl[k].vld);
            chk("tbl_err", err, tbl[k].er);
        end

        // '5' on position 0: single upd exactly STABLE+1 edges after the change
        do_reset();
        c0 = cyc;
        drive(8'hFE, 7'b0100100, 10);
        chk("s5_digit", digits[3:0], 4'd5);
        chk("s5_valid", valid, 8'h01);
        chk("s5_updcnt", upd_cnt, 1);
        chk("s5_latency", last_upd - c0, STABLE + 1);
        chk("s5_err", err, 1'b0);

        // scan between positions 0 and 1
        do_reset();
        for (int r = 0; r < 2; r++) begin
            drive(8'hFE, 7'b0000100, 16);
            drive(8'hFD, 7'b0000110, 16);
        end
        drive(8'hFE, 7'b0000100, 16);
        chk("scan_digits", digits[7:0], 8'h39);
        chk("scan_frames", frame_cnt, 2);

        // segments toggling faster than the stability window
        do_reset();
        for (int r = 0; r < 10; r++)
            drive(8'hFB, (r % 2) ? 7'b1001111 : 7'b0001111, 2);
        chk("tog_updcnt", upd_cnt, 0);
        chk("tog_valid", valid, 8'h00);

        // ghosting sets err, digits untouched, err sticky until reset
        do_reset();
        drive(8'hFE, 7'b0100100, 6);
        drive(8'hFC, 7'b0100100, 8);
        chk("ghost_err", err, 1'b1);
        chk("ghost_digit", digits[3:0], 4'd5);
        drive(8'hFE, 7'b0000110, 8);
        drive(8'hFF, 7'b1111111, 4);
        chk("ghost_sticky", err, 1'b1);
        do_reset();
        chk("ghost_clr", err, 1'b0);

        // reset while the counter is at 3, then a full window is needed
        drive(8'hFE, 7'b0100100, 4);
        do_reset();
        chk("rmid_digits", digits, '0);
        c0 = cyc - 1;  // release happened just after edge c0+1's predecessor
        c0 = cyc;
        repeat (STABLE) tick();
        chk("rmid_early", valid, 8'h00);
        tick();
        chk("rmid_cap", valid, 8'h01);
        chk("rmid_latency", last_upd - c0, STABLE + 1);

        // random scan traffic, clean patterns only
        do_reset();
        for (int r = 0; r < 250; r++) begin
            a = '1;
            a[$urandom_range(0, NDIG-1)] = 1'b0;
            if ($urandom_range(0, 9) == 0) s = 7'h7F;
            else s = ~CODES[$urandom_range(0, 9)];
            hold = $urandom_range(1, 8);
            drive(a, s, hold);
        end

        // random traffic including ghosts, idle and garbage patterns
        do_reset();
        for (int r = 0; r < 250; r++) begin
            a = '1;
            case ($urandom_range(0, 19))
                0:       a = '1;
                1:       begin
                             a[$urandom_range(0, NDIG-1)] = 1'b0;
                             a[$urandom_range(0, NDIG-1)] = 1'b0;
                         end
                default: a[$urandom_range(0, NDIG-1)] = 1'b0;
            endcase
            case ($urandom_range(0, 9))
                0:       s = 7'($urandom);
                1:       s = 7'h7F;
                default: s = ~CODES[$urandom_range(0, 15)];
            endcase
            hold = $urandom_range(1, 8);
            drive(a, s, hold);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
